adder_4b: RTL and testbench

Registered unsigned 4-bit adder with carry-in and a valid-qualified input/output pair. It adds two 4-bit operands plus a carry bit and returns the full 5-bit sum, carry-out included, one clock after the operands are accepted. The block is a leaf arithmetic element in the datapath, used wherever a small sum with explicit carry-out is needed. The core is a ripple-carry chain of full-adder cells, followed by an output register stage.

---
 rtl/adder_4b.sv | 68 ++++++
 tb/tb_adder_4b.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_4b.sv
// Registered unsigned WIDTH-bit ripple-carry adder (c = a + b + cin); ADDER_4B_OVF_EN adds a registered signed-overflow flag.
// Latency 1 cycle from the in_valid edge to c/out_valid; throughput 1 sum per cycle.
// No backpressure: a new operand set is accepted on every in_valid edge and the block never stalls.
module adder_4b #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH:0]   c,
`ifdef ADDER_4B_OVF_EN
   output logic             ovf,
`endif
   output logic             out_valid
);

   logic [WIDTH:0]   k;
   logic [WIDTH-1:0] s;
   logic [WIDTH:0]   c_d;
   logic [WIDTH:0]   c_q;
   logic             vld_q;

   assign k[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ k[i];
      assign k[i+1] = (a[i] & b[i]) | (a[i] & k[i]) | (b[i] & k[i]);
   end

   assign c_d = {k[WIDTH], s};

   // c only loads on accepted operands, so X/Z on idle inputs never reaches it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_q   <= '0;
         vld_q <= 1'b0;
      end else begin
         vld_q <= in_valid;
         if (in_valid) begin
            c_q <= c_d;
         end
      end
   end

   assign c         = c_q;
   assign out_valid = vld_q;

`ifdef ADDER_4B_OVF_EN
   logic ovf_d;
   logic ovf_q;

   assign ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (in_valid) begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_adder_4b.sv
// Directed-vector bench for adder_4b; overflow checks are compiled in with ADDER_4B_OVF_EN.
module tb_adder_4b;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [3:0] a;
   logic [3:0] b;
   logic       cin;
   logic [4:0] c;
   logic       out_valid;
`ifdef ADDER_4B_OVF_EN
   logic       ovf;
`endif

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   adder_4b #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .c         (c),
`ifdef ADDER_4B_OVF_EN
      .ovf       (ovf),
`endif
      .out_valid (out_valid)
   );

   task automatic drive(input logic v, input logic [3:0] aa, input logic [3:0] bb, input logic ci);
      @(negedge clk);
      in_valid = v;
      a        = aa;
      b        = bb;
      cin      = ci;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      in_valid = 1'b1;
      a        = 4'($urandom_range(0, 15));
      b        = 4'($urandom_range(0, 15));
      cin      = 1'($urandom_range(0, 1));
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (c !== 5'd0 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_hold: c=%0d out_valid=%b, required c=0 out_valid=0", c, out_valid);
      end
`ifdef ADDER_4B_OVF_EN
      vectors++;
      if (ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ovf: ovf=%b, required 0", ovf);
      end
`endif
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (c !== 5'd0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle%0d: c=%0d out_valid=%b, required c=0 out_valid=0", i, c, out_valid);
         end
      end
   endtask

   task automatic test_basic();
      drive(1'b1, 4'b0111, 4'b1011, 1'b0);
      @(posedge clk);
      #1;
      vectors++;
      if (c !== 5'b10010 || out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL basic_add: c=%0d out_valid=%b, required c=18 out_valid=1", c, out_valid);
      end
`ifdef ADDER_4B_OVF_EN
      vectors++;
      if (ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_ovf: ovf=%b, required 0", ovf);
      end
`endif
      // Idle cycle with unknown operands: c must hold.
      drive(1'b0, 4'bxxxx, 4'bzzzz, 1'bx);
      @(posedge clk);
      #1;
      vectors++;
      if (c !== 5'd18 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_hold: c=%0d out_valid=%b, required c=18 out_valid=0", c, out_valid);
      end
   endtask

   task automatic test_carry_extremes();
      logic [3:0] ta   [3] = '{4'hF, 4'h0, 4'h8};
      logic [3:0] tb   [3] = '{4'hF, 4'h0, 4'h8};
      logic       tci  [3] = '{1'b1, 1'b1, 1'b0};
      logic [4:0] tc   [3] = '{5'd31, 5'd1, 5'b10000};
      logic       tovf [3] = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, ta[i], tb[i], tci[i]);
         @(posedge clk);
         #1;
         vectors++;
         if (c !== tc[i] || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL carry_ext%0d: c=%0d out_valid=%b, required c=%0d out_valid=1", i, c, out_valid, tc[i]);
         end
`ifdef ADDER_4B_OVF_EN
         vectors++;
         if (ovf !== tovf[i]) begin
            miscompares++;
            $display("FAIL carry_ovf%0d: ovf=%b, required %b", i, ovf, tovf[i]);
         end
`else
         if (tovf[i] === 1'bx) $display("unused");
`endif
         drive(1'b0, 4'h0, 4'h0, 1'b0);
         @(posedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] sa [4] = '{4'd1, 4'd3, 4'd15, 4'd9};
      logic [3:0] sb [4] = '{4'd2, 4'd4, 4'd1, 4'd6};
      logic [4:0] sc [4] = '{5'd3, 5'd7, 5'd16, 5'd15};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, sa[i], sb[i], 1'b0);
         @(posedge clk);
         #1;
         vectors++;
         if (c !== sc[i] || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stream%0d: c=%0d out_valid=%b, required c=%0d out_valid=1", i, c, out_valid, sc[i]);
         end
      end
      drive(1'b0, 4'h0, 4'h0, 1'b0);
      @(posedge clk);
      #1;
      vectors++;
      if (c !== 5'd15 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL stream_end: c=%0d out_valid=%b, required c=15 out_valid=0", c, out_valid);
      end
   endtask

   task automatic test_async_reset();
      drive(1'b1, 4'd5, 4'd6, 1'b0);
      @(posedge clk);
      #1;
      vectors++;
      if (c !== 5'd11 || out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL areset_pre: c=%0d out_valid=%b, required c=11 out_valid=1", c, out_valid);
      end
      // Pending operand for the next edge, then reset lands between edges.
      a   = 4'd2;
      b   = 4'd3;
      #1;
      rst = 1'b1;
      #1;
      vectors++;
      if (c !== 5'd0 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL areset_immediate: c=%0d out_valid=%b, required c=0 out_valid=0", c, out_valid);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (c !== 5'd0 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL areset_discard: c=%0d out_valid=%b, required c=0 out_valid=0", c, out_valid);
      end
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      vectors++;
      if (c !== 5'd0 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL areset_after: c=%0d out_valid=%b, required c=0 out_valid=0", c, out_valid);
      end
   endtask

   task automatic test_exhaustive();
      int         bad = 0;
      logic [4:0] exp_c;
      int         ssum;
      logic       exp_ovf;
      for (int i = 0; i < 512; i++) begin
         logic [3:0] ea = 4'(i >> 5);
         logic [3:0] eb = 4'(i >> 1);
         logic       ec = 1'(i);
         drive(1'b1, ea, eb, ec);
         exp_c   = 5'({1'b0, ea} + {1'b0, eb} + {4'b0, ec});
         ssum    = int'($signed(ea)) + int'($signed(eb)) + int'(ec);
         exp_ovf = (ssum > 7) || (ssum < -8);
         @(posedge clk);
         #1;
         vectors++;
         if (c !== exp_c || out_valid !== 1'b1) begin
            miscompares++;
            if (bad++ < 8)
               $display("FAIL exh a=%0d b=%0d cin=%0d: c=%0d out_valid=%b, required c=%0d out_valid=1",
                        ea, eb, ec, c, out_valid, exp_c);
         end
`ifdef ADDER_4B_OVF_EN
         vectors++;
         if (ovf !== exp_ovf) begin
            miscompares++;
            if (bad++ < 8)
               $display("FAIL exh_ovf a=%0d b=%0d cin=%0d: ovf=%b, required %b", ea, eb, ec, ovf, exp_ovf);
         end
`else
         if (exp_ovf === 1'bx) $display("unused");
`endif
      end
      drive(1'b0, 4'h0, 4'h0, 1'b0);
      @(posedge clk);
   endtask

   initial begin
      in_valid = 1'b0;
      a        = 4'h0;
      b        = 4'h0;
      cin      = 1'b0;
      rst      = 1'b0;
      test_reset();
      test_basic();
      test_carry_extremes();
      test_back_to_back();
      test_async_reset();
      test_exhaustive();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
